// File: rtl/vfd_pkg.sv
// Shared definitions for the VFD timing blocks.
// Contents:
//   CNT_W_DEF       - default width of cycle counters and measurement outputs
//   TIMEOUT_CYC_DEF - default number of cycles without a rising edge before
//                     a source is declared stalled
//   state_e         - period meter state encoding
package vfd_pkg;

  localparam int CNT_W_DEF       = 24;
  localparam int TIMEOUT_CYC_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_e;

endpackage

// File: rtl/vfd_period_meter_if.sv
// Bundle between the period meter and its user.
// Signals:
//   enable       - measurement enable (user -> meter)
//   sig_in       - asynchronous square wave to measure (user -> meter)
//   period       - cycles between the last two rising edges (meter -> user)
//   high_time    - cycles from rise to fall in that period (meter -> user)
//   period_valid - one-cycle pulse when period/high_time update
//   stalled      - no rising edge for the timeout interval
// Modports: master = user side, slave = meter side.
interface vfd_period_meter_if #(
  parameter int CNT_W = vfd_pkg::CNT_W_DEF
);

  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             stalled;

  modport master (
    output enable, sig_in,
    input  period, high_time, period_valid, stalled
  );

  modport slave (
    input  enable, sig_in,
    output period, high_time, period_valid, stalled
  );

endinterface

// File: rtl/vfd_sync_edge.sv
// Two-flop synchronizer plus one delay flop with rise/fall decode for an
// asynchronous single-bit input.
// Ports:
//   clk_in   - system clock
//   reset    - synchronous, active-high; all flops reset to 1
//   async_in - asynchronous input
//   rise     - one-cycle pulse on a synchronized 0->1 transition
//   fall     - one-cycle pulse on a synchronized 1->0 transition
module vfd_sync_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic d_q,  d_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    d_d  = s2_q;
  end

  // Reset to 1 so an input already high at reset release is not seen as a rise.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      d_q  <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      d_q  <= d_d;
    end
  end

  assign rise = s2_q & ~d_q;
  assign fall = ~s2_q & d_q;

endmodule

// File: rtl/vfd_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// clk_in cycles, and flags a source that stops toggling.
// Ports:
//   clk_in - system clock
//   reset  - synchronous, active-high
//   bus    - vfd_period_meter_if slave: enable, sig_in in;
//            period, high_time, period_valid, stalled out
// Parameters:
//   CNT_W       - counter / output width
//   TIMEOUT_CYC - cycles without a rise before stalled is raised
//                 (must be < 2**CNT_W)
module vfd_period_meter
  import vfd_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk_in,
  input  logic                  reset,
  vfd_period_meter_if.slave     bus
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  logic rise, fall;

  state_e           state_q,        state_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [CNT_W-1:0] hi_pend_q,      hi_pend_d;
  logic [CNT_W-1:0] period_q,       period_d;
  logic [CNT_W-1:0] high_time_q,    high_time_d;
  logic             period_valid_q, period_valid_d;
  logic             stalled_q,      stalled_d;

  vfd_sync_edge u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .async_in (bus.sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  // cnt holds the number of cycles since the last rise detection, so at the
  // next rise it equals the period and at a fall it equals the high time.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hi_pend_d      = hi_pend_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    stalled_d      = stalled_q;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          // First rise only arms; there is no prior edge to measure from.
          if (rise) begin
            cnt_d   = ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (fall) hi_pend_d = cnt_q;
          // A rise takes priority over the timeout in the same cycle.
          if (rise) begin
            period_d       = cnt_q;
            high_time_d    = hi_pend_q;
            period_valid_d = 1'b1;
            stalled_d      = 1'b0;
            cnt_d          = ONE;
          end else if (cnt_q == TIMEOUT_V) begin
            stalled_d = 1'b1;
            state_d   = STALL;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        STALL: begin
          // stalled is left set until a full period has been measured again.
          if (rise) begin
            cnt_d   = ONE;
            state_d = MEASURE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      hi_pend_q      <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hi_pend_q      <= hi_pend_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.high_time    = high_time_q;
  assign bus.period_valid = period_valid_q;
  assign bus.stalled      = stalled_q;

endmodule

// File: tb/tb_vfd_period_meter.sv
module tb_vfd_period_meter;
  import vfd_pkg::*;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT_CYC = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_drv  = 1'b1;
  logic sig_drv = 1'b0;
  logic use_div = 1'b0;
  logic div_run = 1'b0;
  logic div_out;
  logic [9:0] div_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int p; int h; } exp_t;
  exp_t exp_q[$];
  logic prev_vld = 1'b0;

  always #5 clk = ~clk;

  vfd_period_meter_if #(.CNT_W(CNT_W)) bus ();

  assign bus.enable = en_drv;
  assign bus.sig_in = use_div ? div_out : sig_drv;

  vfd_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_in (clk),
    .reset  (rst),
    .bus    (bus)
  );

  // Toggle divider on the same clock: half period 336 cycles.
  always_ff @(posedge clk) begin
    if (!div_run) begin
      div_cnt <= '0;
      div_out <= 1'b0;
    end else if (div_cnt == 10'd335) begin
      div_cnt <= '0;
      div_out <= ~div_out;
    end else begin
      div_cnt <= div_cnt + 10'd1;
    end
  end

  // Monitor: every period_valid pops one expected measurement.
  always @(negedge clk) begin
    if (bus.period_valid) begin
      if (prev_vld) begin
        n_vec++; n_err++;
        $display("FAIL valid_width: period_valid high on two consecutive cycles at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_valid: period=%0d high_time=%0d, none required at %0t",
                 bus.period, bus.high_time, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if (int'(bus.period) != e.p || int'(bus.high_time) != e.h) begin
          n_err++;
          $display("FAIL measurement: got period=%0d high_time=%0d, required %0d/%0d at %0t",
                   bus.period, bus.high_time, e.p, e.h, $time);
        end
      end
    end
    prev_vld = bus.period_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input int h);
    exp_t e;
    e.p = p;
    e.h = h;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sig_drv = v;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset state, then 100/40 wave.
    sig_drv = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_period",    int'(bus.period),       0);
    chk("rst_high_time", int'(bus.high_time),    0);
    chk("rst_valid",     int'(bus.period_valid), 0);
    chk("rst_stalled",   int'(bus.stalled),      0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) push(100, 40);
      drive(1'b1, 40);
      drive(1'b0, 60);
    end
    push(100, 40);

    // Test 3: stall exactly TIMEOUT_CYC cycles after the last rise detection.
    drive(1'b1, 40);
    for (int j = 40; j <= 1010; j++) begin
      @(negedge clk);
      sig_drv = 1'b0;
      if (j == 1002) chk("stall_early", int'(bus.stalled), 0);
      if (j == 1003) begin
        chk("stall_set",    int'(bus.stalled), 1);
        chk("stall_period", int'(bus.period),  100);
      end
    end
    drive(1'b1, 100);
    chk("stall_hold_after_arm", int'(bus.stalled), 1);
    drive(1'b0, 100);
    push(200, 100);
    drive(1'b1, 100);
    chk("stall_cleared", int'(bus.stalled), 0);
    drive(1'b0, 100);

    // Test 2: input high through reset release, no false arming.
    @(negedge clk);
    sig_drv = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 20);
    drive(1'b0, 30);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push(100, 40);
      drive(1'b1, 40);
      drive(1'b0, 60);
    end

    // Test 4: 336-count toggle divider source.
    do_reset(3);
    push(672, 336);
    push(672, 336);
    push(672, 336);
    use_div = 1'b1;
    div_run = 1'b1;
    repeat (2452) @(negedge clk);
    chk("div_last_period", int'(bus.period), 672);
    sig_drv = 1'b1;
    use_div = 1'b0;
    div_run = 1'b0;

    // Test 5: enable dropped mid-period for 50 cycles.
    do_reset(3);
    drive(1'b1, 10);
    drive(1'b0, 60);
    drive(1'b1, 40);
    drive(1'b0, 60);
    push(100, 40);
    drive(1'b1, 40);
    drive(1'b0, 20);
    en_drv = 1'b0;
    drive(1'b0, 30);
    drive(1'b1, 20);
    chk("dis_period_hold", int'(bus.period),    100);
    chk("dis_high_hold",   int'(bus.high_time), 40);
    en_drv = 1'b1;
    drive(1'b1, 20);
    drive(1'b0, 60);
    drive(1'b1, 40);
    drive(1'b0, 60);
    push(100, 40);
    drive(1'b1, 40);
    drive(1'b0, 30);

    // Test 6: one-cycle reset mid-measurement.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_period",    int'(bus.period),       0);
    chk("mid_rst_high_time", int'(bus.high_time),    0);
    chk("mid_rst_stalled",   int'(bus.stalled),      0);
    chk("mid_rst_valid",     int'(bus.period_valid), 0);
    chk("mid_rst_state",     int'(dut.state_q),      int'(IDLE));
    drive(1'b0, 30);
    drive(1'b1, 40);
    drive(1'b0, 60);
    push(100, 40);
    drive(1'b1, 40);
    drive(1'b0, 60);

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
